ibex_rf_write_sequencer: RTL and testbench

IBEX_RF_WRITE_SEQUENCER -- requirements
Module: ibex_rf_write_sequencer

---
 rtl/ibex_rf_write_sequencer.sv | 148 ++++++++++++++
 tb/tb_ibex_rf_write_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/ibex_rf_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ibex_rf_write_sequencer
// Description : Arbitrates the register-file write port between a power-on
//               clear sweep, the core write port and a lockstep recovery
//               writer that restores register contents after a setback.
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_rf_write_sequencer #(
  parameter bit          RV32E          = 1'b0,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned RestoreTimeout = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 setback_i,
  input  logic                 core_we_i,
  input  logic [4:0]           core_waddr_i,
  input  logic [DataWidth-1:0] core_wdata_i,
  input  logic                 rec_req_i,
  input  logic                 rec_last_i,
  input  logic [4:0]           rec_waddr_i,
  input  logic [DataWidth-1:0] rec_wdata_i,
  output logic                 rec_gnt_o,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 busy_o,
  output logic                 init_done_o,
  output logic                 restore_err_o
);

  // Highest architectural register; the sweep writes 1..LAST.
  localparam logic [4:0] LAST    = RV32E ? 5'd15 : 5'd31;
  localparam logic [7:0] TIMEOUT = 8'(RestoreTimeout);

  localparam logic [1:0] S_CLEAR   = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_RESTORE = 2'd2;

  logic [1:0] r_state;
  logic [4:0] r_clr_cnt;
  logic [7:0] r_idle_cnt;
  logic       r_init_done;

  logic                 w_we;
  logic [4:0]           w_waddr;
  logic [DataWidth-1:0] w_wdata;
  logic                 w_gnt;
  logic                 w_busy;
  logic                 w_err;

  // x0 is hardwired to zero; RV32E has no registers 16..31.
  function automatic logic addr_ok(input logic [4:0] a);
    return (a != 5'd0) && !(RV32E && a[4]);
  endfunction

  // Output mux: select the write source for the current state. Reset
  // overrides everything so an abort takes effect in the same cycle.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = 5'd0;
    w_wdata = '0;
    w_gnt   = 1'b0;
    w_busy  = 1'b1;
    w_err   = 1'b0;
    if (!rst_i) begin
      case (r_state)
        S_CLEAR: begin
          w_we    = addr_ok(r_clr_cnt);
          w_waddr = r_clr_cnt;
        end
        S_RUN: begin
          w_busy = 1'b0;
          if (core_we_i) begin
            w_we    = addr_ok(core_waddr_i);
            w_waddr = core_waddr_i;
            w_wdata = core_wdata_i;
          end
        end
        S_RESTORE: begin
          w_gnt = rec_req_i;
          if (rec_req_i) begin
            w_we    = addr_ok(rec_waddr_i);
            w_waddr = rec_waddr_i;
            w_wdata = rec_wdata_i;
          end else if (r_idle_cnt == TIMEOUT) begin
            w_err = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State, sweep counter, idle counter and init flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_CLEAR;
      r_clr_cnt   <= 5'd1;
      r_idle_cnt  <= 8'd0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          if (r_clr_cnt == LAST) begin
            r_state     <= S_RUN;
            r_init_done <= 1'b1;
          end else begin
            r_clr_cnt <= r_clr_cnt + 5'd1;
          end
        end
        S_RUN: begin
          if (setback_i) begin
            r_state    <= S_RESTORE;
            r_idle_cnt <= 8'd0;
          end
        end
        S_RESTORE: begin
          if (rec_req_i) begin
            r_idle_cnt <= 8'd0;
            if (rec_last_i) begin
              r_state <= S_RUN;
            end
          end else if (r_idle_cnt == TIMEOUT) begin
            r_state <= S_RUN;
          end else begin
            r_idle_cnt <= r_idle_cnt + 8'd1;
          end
        end
        default: begin
          r_state   <= S_CLEAR;
          r_clr_cnt <= 5'd1;
        end
      endcase
    end
  end

  assign rf_we_o       = w_we;
  assign rf_waddr_o    = w_waddr;
  assign rf_wdata_o    = w_wdata;
  assign rec_gnt_o     = w_gnt;
  assign busy_o        = w_busy;
  assign restore_err_o = w_err;
  assign init_done_o   = r_init_done & ~rst_i;

endmodule
`default_nettype wire

// File: tb/tb_ibex_rf_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ibex_rf_write_sequencer
// Description : Self-checking bench; two configurations (RV32I timeout 4,
//               RV32E timeout 6) driven by shared stimulus and compared
//               against a behavioural model every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ibex_rf_write_sequencer;

  logic        clk = 1'b0;
  logic        rst, setback, core_we, rec_req, rec_last;
  logic [4:0]  core_waddr, rec_waddr;
  logic [31:0] core_wdata, rec_wdata;

  logic        gnt0, we0, busy0, done0, err0;
  logic        gnt1, we1, busy1, done1, err1;
  logic [4:0]  waddr0, waddr1;
  logic [31:0] wdata0, wdata1;

  int n_pass  = 0;
  int n_total = 0;

  // Model state per instance: mode 0=clearing, 1=running, 2=restoring.
  int m_mode[2];
  int m_clr[2];
  int m_idle[2];
  bit m_done[2];
  int LASTV[2] = '{31, 15};
  int TOV[2]   = '{4, 6};
  bit EV[2]    = '{1'b0, 1'b1};

  always #5 clk = ~clk;

  ibex_rf_write_sequencer #(.RV32E(1'b0), .DataWidth(32), .RestoreTimeout(4)) dut0 (
    .clk_i(clk), .rst_i(rst), .setback_i(setback),
    .core_we_i(core_we), .core_waddr_i(core_waddr), .core_wdata_i(core_wdata),
    .rec_req_i(rec_req), .rec_last_i(rec_last), .rec_waddr_i(rec_waddr), .rec_wdata_i(rec_wdata),
    .rec_gnt_o(gnt0), .rf_we_o(we0), .rf_waddr_o(waddr0), .rf_wdata_o(wdata0),
    .busy_o(busy0), .init_done_o(done0), .restore_err_o(err0));

  ibex_rf_write_sequencer #(.RV32E(1'b1), .DataWidth(32), .RestoreTimeout(6)) dut1 (
    .clk_i(clk), .rst_i(rst), .setback_i(setback),
    .core_we_i(core_we), .core_waddr_i(core_waddr), .core_wdata_i(core_wdata),
    .rec_req_i(rec_req), .rec_last_i(rec_last), .rec_waddr_i(rec_waddr), .rec_wdata_i(rec_wdata),
    .rec_gnt_o(gnt1), .rf_we_o(we1), .rf_waddr_o(waddr1), .rf_wdata_o(wdata1),
    .busy_o(busy1), .init_done_o(done1), .restore_err_o(err1));

  function automatic bit writable(input int a, input bit e);
    return (a != 0) && !(e && a >= 16);
  endfunction

  task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s[dut%0d] observed=%h expected=%h t=%0t", tag, k, obs, exp, $time);
  endtask

  // One cycle: compare at the falling edge, then advance the model.
  task automatic step();
    bit          e_we, e_gnt, e_busy, e_err;
    logic [31:0] e_waddr, e_wdata;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      e_we = 0; e_gnt = 0; e_busy = 1; e_err = 0; e_waddr = 0; e_wdata = 0;
      if (!rst) begin
        if (m_mode[k] == 0) begin
          e_we = 1; e_waddr = 32'(m_clr[k]);
        end else if (m_mode[k] == 1) begin
          e_busy = 0;
          if (core_we) begin
            e_we = writable(int'(core_waddr), EV[k]); e_waddr = 32'(core_waddr); e_wdata = core_wdata;
          end
        end else begin
          e_gnt = rec_req;
          if (rec_req) begin
            e_we = writable(int'(rec_waddr), EV[k]); e_waddr = 32'(rec_waddr); e_wdata = rec_wdata;
          end else e_err = (m_idle[k] == TOV[k]);
        end
      end
      check("rf_we",    k, 32'(k ? we1 : we0),     32'(e_we));
      check("rec_gnt",  k, 32'(k ? gnt1 : gnt0),   32'(e_gnt));
      check("busy",     k, 32'(k ? busy1 : busy0), 32'(e_busy));
      check("rest_err", k, 32'(k ? err1 : err0),   32'(e_err));
      check("init_done",k, 32'(k ? done1 : done0), 32'(m_done[k] && !rst));
      if (!rst) begin
        check("rf_waddr", k, 32'(k ? waddr1 : waddr0), e_waddr);
        check("rf_wdata", k, k ? wdata1 : wdata0,      e_wdata);
      end
      // next-state of the model
      if (rst) begin
        m_mode[k] = 0; m_clr[k] = 1; m_idle[k] = 0; m_done[k] = 0;
      end else if (m_mode[k] == 0) begin
        if (m_clr[k] == LASTV[k]) begin m_mode[k] = 1; m_done[k] = 1; end
        else m_clr[k]++;
      end else if (m_mode[k] == 1) begin
        if (setback) begin m_mode[k] = 2; m_idle[k] = 0; end
      end else begin
        if (rec_req) begin
          m_idle[k] = 0;
          if (rec_last) m_mode[k] = 1;
        end else if (m_idle[k] == TOV[k]) m_mode[k] = 1;
        else m_idle[k]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; setback = 0; core_we = 0; core_waddr = 0; core_wdata = 0;
    rec_req = 0; rec_last = 0; rec_waddr = 0; rec_wdata = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    #1;
    // reset held
    repeat (3) step();
    // release, sweep to address 9, then pulse reset at address 10
    rst = 0;
    repeat (9) step();
    rst = 1; step();
    rst = 0;
    // full sweep for both configurations
    repeat (34) step();
    // core write to 0x12 (dropped on RV32E), then to x0
    core_we = 1; core_waddr = 5'h12; core_wdata = 32'h1234_5678; step();
    core_waddr = 5'd0; core_wdata = 32'hFFFF_FFFF; step();
    // write to 5 coincident with setback, then ignored write to 6
    core_waddr = 5'd5; core_wdata = 32'hDEAD_BEEF; setback = 1; step();
    setback = 0; core_waddr = 5'd6; core_wdata = 32'hCAFE_0006; step();
    core_we = 0;
    // recovery words 1, 0, 2(last)
    rec_req = 1; rec_waddr = 5'd1; rec_wdata = 32'h0000_1111; step();
    rec_waddr = 5'd0; rec_wdata = 32'h0000_2222; step();
    rec_waddr = 5'd2; rec_wdata = 32'h0000_3333; rec_last = 1; step();
    idle_inputs(); step();
    // setback then starve the recovery writer until both time out
    setback = 1; step();
    setback = 0;
    repeat (9) step();
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst        = ($urandom_range(0, 149) == 0);
      setback    = ($urandom_range(0, 19) == 0);
      core_we    = $urandom_range(0, 1) == 1;
      core_waddr = 5'($urandom);
      core_wdata = $urandom;
      rec_req    = $urandom_range(0, 3) != 0 && $urandom_range(0, 2) != 0;
      rec_last   = ($urandom_range(0, 9) == 0);
      rec_waddr  = 5'($urandom);
      rec_wdata  = $urandom;
      step();
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
